// File: rtl/game_control.sv
// game_control: per-frame sequencer for the flappy-bird datapath.
// Paces frames, steps delete/update/draw/check, and drives jump and plot.
module game_control #(
    parameter int FRAME_TICKS  = 833333,
    parameter int GUARD        = 6,
    parameter int DRAW_TIMEOUT = 4096
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       go,
    input  logic       jump_key,
    input  logic       finished_draw,
    input  logic       collision,
    output logic [4:0] cur_state,
    output logic       jump,
    output logic       plot,
    output logic       game_over
);

    typedef enum logic [4:0] {
        IDLE           = 5'b00000,
        WAIT_FRAME     = 5'b00001,
        CHECK          = 5'b00010,
        GAME_OVER      = 5'b11111,
        DEL_BIRD       = 5'b01111,
        DEL_WALL_TOP   = 5'b01100,
        DEL_WALL_BOT   = 5'b01001,
        UPDATE_BIRD_VY = 5'b01011,
        UPDATE_BIRD_Y  = 5'b10101,
        UPDATE_WALL    = 5'b01010,
        DRAW_WALL_TOP  = 5'b01101,
        DRAW_WALL_BOT  = 5'b01000,
        DRAW_BIRD      = 5'b00100
    } state_t;

    localparam int FW = (FRAME_TICKS > 1) ? $clog2(FRAME_TICKS) : 1;
    localparam int CW = $clog2(DRAW_TIMEOUT + GUARD + 1);
    localparam logic [FW-1:0] FRAME_LAST = FW'(FRAME_TICKS - 1);
    localparam logic [CW-1:0] GUARD_C    = CW'(GUARD);
    localparam logic [CW-1:0] CNT_LAST   = CW'(DRAW_TIMEOUT - 1);

    state_t        state;
    state_t        state_nxt;
    logic [FW-1:0] frame_cnt;
    logic [CW-1:0] cnt;
    logic          tick_pending;
    logic          jump_req;
    logic          go_q;
    logic          jump_q;
    logic          is_draw;
    logic          guard_done;
    logic          advance;
    logic          wrap;
    logic          go_rise;
    logic          jump_rise;

    always_comb begin
        is_draw = state inside {DEL_BIRD, DEL_WALL_TOP, DEL_WALL_BOT,
                                DRAW_WALL_TOP, DRAW_WALL_BOT, DRAW_BIRD};
        guard_done = cnt >= GUARD_C;
        // A done seen inside the guard window may be stale from the last rectangle
        advance   = (guard_done && finished_draw) || (cnt == CNT_LAST);
        wrap      = frame_cnt == FRAME_LAST;
        go_rise   = go & ~go_q;
        jump_rise = jump_key & ~jump_q;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:           if (go_rise) state_nxt = WAIT_FRAME;
            WAIT_FRAME:     if (tick_pending) state_nxt = DEL_BIRD;
            DEL_BIRD:       if (advance) state_nxt = DEL_WALL_TOP;
            DEL_WALL_TOP:   if (advance) state_nxt = DEL_WALL_BOT;
            DEL_WALL_BOT:   if (advance) state_nxt = UPDATE_BIRD_VY;
            UPDATE_BIRD_VY: state_nxt = UPDATE_BIRD_Y;
            UPDATE_BIRD_Y:  state_nxt = UPDATE_WALL;
            UPDATE_WALL:    state_nxt = DRAW_WALL_TOP;
            DRAW_WALL_TOP:  if (advance) state_nxt = DRAW_WALL_BOT;
            DRAW_WALL_BOT:  if (advance) state_nxt = DRAW_BIRD;
            DRAW_BIRD:      if (advance) state_nxt = CHECK;
            CHECK:          state_nxt = collision ? GAME_OVER : WAIT_FRAME;
            GAME_OVER:      state_nxt = GAME_OVER;
            default:        state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state        <= IDLE;
            frame_cnt    <= '0;
            cnt          <= '0;
            tick_pending <= 1'b0;
            jump_req     <= 1'b0;
            go_q         <= 1'b0;
            jump_q       <= 1'b0;
        end else begin
            state     <= state_nxt;
            frame_cnt <= wrap ? '0 : frame_cnt + FW'(1);
            cnt       <= (is_draw && state_nxt == state) ? cnt + CW'(1) : '0;
            go_q      <= go;
            jump_q    <= jump_key;
            // A fresh wrap outranks consumption so back-to-back ticks are not lost
            if (wrap)
                tick_pending <= 1'b1;
            else if (state == WAIT_FRAME)
                tick_pending <= 1'b0;
            if (state == IDLE || state == GAME_OVER)
                jump_req <= 1'b0;
            else if (jump_rise)
                jump_req <= 1'b1;
            else if (state == UPDATE_BIRD_VY)
                jump_req <= 1'b0;
        end
    end

    assign cur_state = state;
    assign jump      = (state == UPDATE_BIRD_VY) && jump_req;
    assign plot      = is_draw && guard_done && !finished_draw;
    assign game_over = state == GAME_OVER;

endmodule

// File: tb/tb_game_control.sv
// tb_game_control: directed stimulus against a sequence-table model of
// the frame FSM, checked every cycle, plus literal timing expectations.
module tb_game_control;

    localparam int FT = 50;
    localparam int G  = 6;
    localparam int TO = 64;

    localparam logic [4:0] S_IDLE = 5'b00000;
    localparam logic [4:0] S_WAIT = 5'b00001;
    localparam logic [4:0] S_OVER = 5'b11111;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       go = 1'b0;
    logic       jump_key = 1'b0;
    logic       finished_draw = 1'b0;
    logic       collision = 1'b0;
    logic [4:0] cur_state;
    logic       jump;
    logic       plot;
    logic       game_over;

    game_control #(
        .FRAME_TICKS (FT),
        .GUARD       (G),
        .DRAW_TIMEOUT(TO)
    ) dut (
        .clk          (clk),
        .resetn       (resetn),
        .go           (go),
        .jump_key     (jump_key),
        .finished_draw(finished_draw),
        .collision    (collision),
        .cur_state    (cur_state),
        .jump         (jump),
        .plot         (plot),
        .game_over    (game_over)
    );

    always #5 clk = ~clk;

    // Frame order: index 0 is WAIT_FRAME, 10 is CHECK
    logic [4:0] seq [0:10] = '{5'b00001, 5'b01111, 5'b01100, 5'b01001,
                               5'b01011, 5'b10101, 5'b01010, 5'b01101,
                               5'b01000, 5'b00100, 5'b00010};
    int exp_len [0:10] = '{0, 11, 11, 11, 1, 1, 1, 11, 11, 11, 1};

    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;
    int fd_mode = 0;
    int coll_mode = 0;

    // Model: -1 idle, -2 game over, 0..10 position in seq
    int m_idx;
    int m_tis;
    int m_fc;
    bit m_pend;
    bit m_jreq;
    bit m_goq;
    bit m_jkq;

    function automatic logic [4:0] code_of(int idx);
        if (idx == -1) return 5'b00000;
        if (idx == -2) return 5'b11111;
        return seq[idx];
    endfunction

    function automatic bit draw_pos(int idx);
        return idx inside {1, 2, 3, 7, 8, 9};
    endfunction

    task automatic model_reset();
        m_idx = -1; m_tis = 0; m_fc = 0;
        m_pend = 0; m_jreq = 0; m_goq = 0; m_jkq = 0;
    endtask

    task automatic model_step();
        int nxt;
        bit wrap;
        nxt = m_idx;
        wrap = (m_fc == FT - 1);
        if (m_idx == -1) begin
            if (go && !m_goq) nxt = 0;
        end else if (m_idx == -2) begin
            nxt = -2;
        end else if (m_idx == 0) begin
            if (m_pend) nxt = 1;
        end else if (m_idx == 10) begin
            nxt = collision ? -2 : 0;
        end else if (draw_pos(m_idx)) begin
            if ((m_tis >= G && finished_draw) || m_tis == TO - 1)
                nxt = m_idx + 1;
        end else begin
            nxt = m_idx + 1;
        end
        if (wrap) m_pend = 1;
        else if (m_idx == 0) m_pend = 0;
        if (m_idx < 0) m_jreq = 0;
        else if (jump_key && !m_jkq) m_jreq = 1;
        else if (m_idx == 4) m_jreq = 0;
        m_tis = (nxt == m_idx) ? m_tis + 1 : 0;
        m_idx = nxt;
        m_fc = (m_fc + 1) % FT;
        m_goq = go;
        m_jkq = jump_key;
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    task automatic wait_state(input logic [4:0] code, input int budget,
                              input string name);
        int k = 0;
        do begin
            @(posedge clk); #2;
            k++;
        end while (cur_state != code && k < budget);
        check(name, cur_state, code);
    endtask

    task automatic wait_entry(input logic [4:0] code, input int budget,
                              input string name);
        int k = 0;
        while (cur_state == code && k < budget) begin
            @(posedge clk); #2;
            k++;
        end
        wait_state(code, budget, name);
    endtask

    task automatic state_len(input logic [4:0] code, output int len,
                             output int plots);
        len = 0; plots = 0;
        while (cur_state == code && len < 1000) begin
            len++;
            plots += int'(plot);
            @(posedge clk); #2;
        end
    endtask

    task automatic frame_jumps(output int j);
        int k = 0;
        j = 0;
        while (cur_state == seq[1] && k < 200) begin
            @(posedge clk); #2; k++;
        end
        while (cur_state != seq[1] && k < 200) begin
            j += int'(jump);
            @(posedge clk); #2; k++;
        end
    endtask

    task automatic start_game(output int c0);
        @(negedge clk);
        resetn = 0; go = 0; jump_key = 0;
        repeat (2) @(negedge clk);
        resetn = 1;
        c0 = cyc;
        repeat (3) @(negedge clk);
        check("idle_before_go", cur_state, S_IDLE);
        go = 1;
        @(negedge clk);
        go = 0;
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge resetn);
            if (!resetn) model_reset();
            else model_step();
        end
    end

    initial forever begin
        @(negedge clk);
        finished_draw = (fd_mode == 1) || (fd_mode == 2 && m_tis >= 10);
        collision = (coll_mode == 1 && m_idx != 10) ||
                    (coll_mode == 2 && m_idx == 10);
    end

    initial forever begin
        @(posedge clk); #2;
        check("cur_state", cur_state, code_of(m_idx));
        check("jump", jump, int'(m_idx == 4 && m_jreq));
        check("plot", plot,
              int'(draw_pos(m_idx) && m_tis >= G && !finished_draw));
        check("game_over", game_over, int'(m_idx == -2));
    end

    initial begin
        #400000;
        $display("FAIL watchdog: run exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int len, pl, j, c0, e1, e2;
        resetn = 0; go = 1;
        repeat (6) begin
            @(negedge clk);
            jump_key = ~jump_key;
        end

        // Full frame with done arriving 10 cycles into each draw state
        fd_mode = 2;
        start_game(c0);
        wait_state(S_WAIT, 5, "enter_wait");
        wait_state(seq[1], 100, "first_del_bird");
        check("first_tick_cycle", cyc - c0, 51);
        for (int i = 1; i <= 10; i++) begin
            check("seq_code", cur_state, seq[i]);
            state_len(seq[i], len, pl);
            check("seq_len", len, exp_len[i]);
        end
        check("back_to_wait", cur_state, S_WAIT);

        // Stale done held high: guard sets the duration
        fd_mode = 1;
        start_game(c0);
        wait_state(seq[1], 100, "stale_del_bird");
        e1 = cyc;
        check("stale_tick_cycle", e1 - c0, 51);
        state_len(seq[1], len, pl);
        check("stale_len", len, G + 1);
        check("stale_plot", pl, 0);
        wait_entry(seq[1], 100, "stale_next_frame");
        e2 = cyc;
        check("frame_period", e2 - e1, FT);

        // Jump pressed mid-frame
        #1 jump_key = 1;
        repeat (3) @(negedge clk);
        jump_key = 0;
        frame_jumps(j);
        check("jump_mid_frame", j, 1);

        // Jump pressed during UPDATE_BIRD_VY carries to the next frame
        #1 jump_key = 1;
        repeat (2) @(negedge clk);
        jump_key = 0;
        wait_state(seq[4], 60, "reach_vy");
        check("jump_in_vy", jump, 1);
        #1 jump_key = 1;
        repeat (2) @(negedge clk);
        jump_key = 0;
        frame_jumps(j);
        check("jump_rest_frame", j, 0);
        frame_jumps(j);
        check("jump_carried", j, 1);
        frame_jumps(j);
        check("jump_no_extra", j, 0);

        // Timeout with no done at all
        fd_mode = 0;
        wait_entry(seq[2], 100, "timeout_state");
        state_len(seq[2], len, pl);
        check("timeout_len", len, TO);
        check("timeout_plot", pl, TO - G);

        // Collision outside CHECK is ignored
        fd_mode = 1;
        coll_mode = 1;
        wait_entry(seq[10], 400, "reach_check");
        state_len(seq[10], len, pl);
        check("check_len", len, 1);
        check("coll_ignored", cur_state, S_WAIT);
        check("coll_no_over", game_over, 0);

        // Collision during CHECK ends the game
        coll_mode = 2;
        wait_state(S_OVER, 300, "reach_game_over");
        check("over_flag", game_over, 1);
        @(negedge clk); go = 1;
        @(negedge clk); go = 0;
        repeat (120) @(negedge clk);
        check("over_sticky", cur_state, S_OVER);
        check("over_flag_sticky", game_over, 1);
        coll_mode = 0;

        // Asynchronous reset in the middle of a frame
        start_game(c0);
        wait_state(seq[7], 200, "reach_draw_top");
        #1 resetn = 0;
        #1 check("async_abort", cur_state, S_IDLE);
        check("async_plot", plot, 0);
        repeat (2) @(negedge clk);
        resetn = 1;
        repeat (3) @(negedge clk);
        check("idle_after_abort", cur_state, S_IDLE);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
